bnn_pixel_packer: RTL
=====================

Name: bnn_pixel_packer

Overview:
Upstream stage of the tiny BNN accelerator: takes a per-pixel AXI-Stream of grayscale pixels, binarizes each pixel against a runtime threshold, and packs one frame of DATA_WIDTH pixels into a single DATA_WIDTH-bit payload beat. It feeds the accelerator's 64-bit image slave port directly. The block decouples pixel ingest from downstream backpressure with a separate accumulator and output register, and enforces frame framing via tlast.

Parameters:
DATA_WIDTH, 64, pixels per frame = output payload bits (>=2)
PIX_WIDTH, 8, bits per input pixel
TID_WIDTH, 4, stream ID width (matches accelerator)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
cfg_threshold  in  PIX_WIDTH  binarization threshold, sampled on every accepted pixel
s_axis_tdata  in  PIX_WIDTH  unsigned pixel value
s_axis_tvalid  in  1  pixel valid
s_axis_tready  out  1  pixel accept
s_axis_tlast  in  1  last pixel of frame
s_axis_tid  in  TID_WIDTH  frame ID
m_axis_tdata  out  DATA_WIDTH  packed binary frame, bit i = pixel i
m_axis_tvalid  out  1  frame valid
m_axis_tready  in  1  downstream accept
m_axis_tid  out  TID_WIDTH  frame ID
err_short  out  1  one-cycle pulse: tlast before DATA_WIDTH pixels
err_long  out  1  one-cycle pulse: DATA_WIDTH pixels without tlast

Behaviour:
- Clock/reset: one clock clk; rst asynchronous, active-high. Reset: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tid=0, err_short=0, err_long=0, s_axis_tready=1 one cycle after rst deassertion; state=ACCUM, pix_cnt=0, acc=0, acc_full=0. Reset mid-frame discards the partial frame and any held output.
- Binarize: bit = (pixel >= cfg_threshold), unsigned compare. Bit written at acc[pix_cnt]; first pixel of frame -> bit 0.
- TID: captured from the first beat of a frame (pix_cnt==0); later beats' tid ignored.
- pix_cnt: 0..DATA_WIDTH-1, width $clog2(DATA_WIDTH).
- States: ACCUM (collecting), DROP (discarding overlong-frame tail).
- ACCUM, beat accepted:
  - tlast && pix_cnt==DATA_WIDTH-1: frame complete, normal.
  - tlast && pix_cnt<DATA_WIDTH-1: frame complete, unfilled bits forced 0, err_short pulses next cycle.
  - !tlast && pix_cnt==DATA_WIDTH-1: frame complete, err_long pulses next cycle, -> DROP.
  - otherwise pix_cnt++.
- DROP: s_axis_tready=1 (subject to acc_full rule below), beats discarded; accepted tlast -> ACCUM, pix_cnt=0.
- Frame completion: if output register free (m_axis_tvalid==0, or m_axis_tvalid && m_axis_tready this cycle), frame loads output register at that edge -> m_axis_tvalid=1 next cycle (1-cycle latency from last pixel). Otherwise frame parks in acc (acc_full=1).
- s_axis_tready = !acc_full (registered-flag based, no combinational path from m_axis_tready).
- acc_full && output register free -> transfer acc to output register, acc_full=0, acc cleared, pix_cnt=0.
- Output: m_axis_tvalid held with stable tdata/tid until m_axis_tready; clears on handshake unless a new frame loads the same edge (back-to-back, no bubble).
- Sustained throughput: one pixel per cycle, no stall, if downstream accepts within DATA_WIDTH cycles.
- cfg_threshold change mid-frame affects only subsequently accepted pixels.

Decomposition:
- Shared package bnn_pkg: DATA_WIDTH/TID_WIDTH defaults shared with accelerator, pack_state_e enum {ACCUM, DROP}.
- No sub-module required; optional bnn_out_reg (1-entry AXI-Stream holding register) if reused by accelerator output side.

Test Plan:
- Threshold 128, 64 pixels alternating 200,50 with tlast on 64th, tid=3, m_axis_tready=1 -> one beat tdata=0x5555_5555_5555_5555, tid=3, tvalid exactly 1 cycle after last pixel accepted.
- Two frames back-to-back (all 255, then all 0, thr=1) with m_axis_tready=1 -> beats 0xFFFF_FFFF_FFFF_FFFF then 0x0, s_axis_tready never drops.
- m_axis_tready=0 for 200 cycles, three frames offered -> frame1 in output reg, frame2 parked, s_axis_tready=0 from frame2 completion; release -> frames emitted in order, tid preserved, none lost.
- Frame of 10 pixels all 255 with tlast, thr=0 -> tdata=0x3FF, err_short pulse 1 cycle, next frame aligned normally.
- 70 pixels all 255, tlast on 70th -> one beat 0xFFFF_FFFF_FFFF_FFFF, err_long pulse, pixels 65-70 dropped, next frame normal.
- Assert rst mid-frame (after 30 pixels) and with tvalid held -> outputs zero asynchronously; next full frame emits correctly with no residue from partial frame.

Source files
------------

// File: rtl/bnn_pkg.sv
// Shared definitions for the BNN accelerator and its pixel packer front end.
// Holds stream widths common to both sides and the packer state encoding.
package bnn_pkg;

    localparam int unsigned BNN_DATA_WIDTH = 64;
    localparam int unsigned BNN_PIX_WIDTH  = 8;
    localparam int unsigned BNN_TID_WIDTH  = 4;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        DROP  = 1'b1
    } pack_state_e;

endpackage

// File: rtl/bnn_pixel_packer.sv
// Binarizes a per-pixel AXI-Stream against a runtime threshold and packs one frame of
// DATA_WIDTH pixels into a single DATA_WIDTH-bit beat, with a parking accumulator.
module bnn_pixel_packer
    import bnn_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = BNN_DATA_WIDTH,
    parameter int unsigned PIX_WIDTH  = BNN_PIX_WIDTH,
    parameter int unsigned TID_WIDTH  = BNN_TID_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PIX_WIDTH-1:0]  cfg_threshold,
    input  logic [PIX_WIDTH-1:0]  s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic [TID_WIDTH-1:0]  s_axis_tid,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [TID_WIDTH-1:0]  m_axis_tid,
    output logic                  err_short,
    output logic                  err_long
);

    localparam int unsigned            CNT_WIDTH = $clog2(DATA_WIDTH);
    localparam logic [CNT_WIDTH-1:0]   CNT_MAX   = CNT_WIDTH'(DATA_WIDTH - 1);

    pack_state_e           state_q, state_d;
    logic [CNT_WIDTH-1:0]  pix_cnt_q, pix_cnt_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [TID_WIDTH-1:0]  acc_tid_q, acc_tid_d;
    logic                  acc_full_q, acc_full_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [TID_WIDTH-1:0]  out_tid_q, out_tid_d;
    logic                  out_valid_q, out_valid_d;
    logic                  err_short_q, err_short_d;
    logic                  err_long_q, err_long_d;

    logic                  out_free;
    logic                  accept;
    logic                  pix_bit;
    logic                  last_slot;
    logic [DATA_WIDTH-1:0] frame_bits;
    logic [TID_WIDTH-1:0]  frame_tid;

    always_comb begin
        out_free   = !out_valid_q || m_axis_tready;
        accept     = s_axis_tvalid && !acc_full_q;
        pix_bit    = (s_axis_tdata >= cfg_threshold);
        last_slot  = (pix_cnt_q == CNT_MAX);
        frame_bits = acc_q;
        frame_bits[pix_cnt_q] = pix_bit;
        frame_tid  = (pix_cnt_q == '0) ? s_axis_tid : acc_tid_q;

        state_d     = state_q;
        pix_cnt_d   = pix_cnt_q;
        acc_d       = acc_q;
        acc_tid_d   = acc_tid_q;
        acc_full_d  = acc_full_q;
        out_data_d  = out_data_q;
        out_tid_d   = out_tid_q;
        out_valid_d = out_valid_q;
        err_short_d = 1'b0;
        err_long_d  = 1'b0;

        if (out_valid_q && m_axis_tready) begin
            out_valid_d = 1'b0;
        end

        // A parked frame has priority; input is stalled while it waits.
        if (acc_full_q) begin
            if (out_free) begin
                out_data_d  = acc_q;
                out_tid_d   = acc_tid_q;
                out_valid_d = 1'b1;
                acc_full_d  = 1'b0;
                acc_d       = '0;
                pix_cnt_d   = '0;
            end
        end else if (accept) begin
            unique case (state_q)
                ACCUM: begin
                    if (s_axis_tlast || last_slot) begin
                        err_short_d = s_axis_tlast && !last_slot;
                        err_long_d  = !s_axis_tlast && last_slot;
                        state_d     = (!s_axis_tlast && last_slot) ? DROP : ACCUM;
                        pix_cnt_d   = '0;
                        if (out_free) begin
                            out_data_d  = frame_bits;
                            out_tid_d   = frame_tid;
                            out_valid_d = 1'b1;
                            acc_d       = '0;
                        end else begin
                            acc_d      = frame_bits;
                            acc_tid_d  = frame_tid;
                            acc_full_d = 1'b1;
                        end
                    end else begin
                        acc_d     = frame_bits;
                        acc_tid_d = frame_tid;
                        pix_cnt_d = pix_cnt_q + 1'b1;
                    end
                end
                DROP: begin
                    if (s_axis_tlast) begin
                        state_d   = ACCUM;
                        pix_cnt_d = '0;
                    end
                end
                default: state_d = ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ACCUM;
            pix_cnt_q   <= '0;
            acc_q       <= '0;
            acc_tid_q   <= '0;
            acc_full_q  <= 1'b0;
            out_data_q  <= '0;
            out_tid_q   <= '0;
            out_valid_q <= 1'b0;
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pix_cnt_q   <= pix_cnt_d;
            acc_q       <= acc_d;
            acc_tid_q   <= acc_tid_d;
            acc_full_q  <= acc_full_d;
            out_data_q  <= out_data_d;
            out_tid_q   <= out_tid_d;
            out_valid_q <= out_valid_d;
            err_short_q <= err_short_d;
            err_long_q  <= err_long_d;
        end
    end

    assign s_axis_tready = !acc_full_q;
    assign m_axis_tdata  = out_data_q;
    assign m_axis_tid    = out_tid_q;
    assign m_axis_tvalid = out_valid_q;
    assign err_short     = err_short_q;
    assign err_long      = err_long_q;

endmodule
